// File: rtl/bridge_pio_out.sv
// Avalon-MM write slave driving a parallel output port with atomic set/clear and a one-shot pulse.
// Optional register readback is enabled by defining BRIDGE_PIO_OUT_READBACK_EN.
module bridge_pio_out #(
    parameter int                    DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int                    PULSE_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [DATA_WIDTH-1:0]      mask_q, mask_d;
    logic [PULSE_CNT_WIDTH-1:0] len_q, len_d;
    logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                       wr_en;
    logic                       trigger;
    logic                       busy;
    logic [DATA_WIDTH-1:0]      wd_data;
    logic [PULSE_CNT_WIDTH-1:0] wd_len;
    logic                       unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign trigger      = wr_en && (address == 3'd2);
    assign wd_data      = writedata[DATA_WIDTH-1:0];
    assign wd_len       = writedata[PULSE_CNT_WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign busy         = (state_q == PULSE);
    assign pulse_busy   = busy;

    always_comb begin
        data_d  = data_q;
        len_d   = len_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (wr_en) begin
            case (address)
                3'd0:    data_d = wd_data;
                3'd1:    len_d  = wd_len;
                3'd4:    data_d = data_q | wd_data;
                3'd5:    data_d = data_q & ~wd_data;
                default: ;
            endcase
        end

        // A trigger always samples len_q as it stood before this edge.
        case (state_q)
            IDLE: begin
                if (trigger && (len_q != '0)) begin
                    mask_d  = wd_data;
                    cnt_d   = len_q;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (trigger) begin
                    if (len_q != '0) begin
                        mask_d = wd_data;
                        cnt_d  = len_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q <= PULSE_CNT_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - PULSE_CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BRIDGE_PIO_OUT_READBACK_EN
    logic [31:0] readdata_q, readdata_d;

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0: readdata_d = 32'(data_q);
            3'd1: readdata_d = 32'(len_q);
            3'd2: begin
                readdata_d     = 32'(mask_q);
                readdata_d[31] = busy;
            end
            3'd3: readdata_d = 32'(cnt_q);
            default: ;
        endcase
    end

    assign readdata = readdata_q;
`else
    assign readdata = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= RESET_VALUE;
            len_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
`ifdef BRIDGE_PIO_OUT_READBACK_EN
            readdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
`ifdef BRIDGE_PIO_OUT_READBACK_EN
            readdata_q <= readdata_d;
`endif
        end
    end

    // Pulse mask overlays the data register only while a pulse is active.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
        assign out_port[gi] = data_q[gi] | (busy & mask_q[gi]);
    end

endmodule

// File: tb/tb_bridge_pio_out.sv
// Table-driven bench for bridge_pio_out: one vector per clock, expectations queued and checked after each edge.
module tb_bridge_pio_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata0, readdata1;
    logic [7:0]  out_port0, out_port1;
    logic        pulse_busy0, pulse_busy1;

    always #5 clk = ~clk;

    bridge_pio_out #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .PULSE_CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0),
        .out_port(out_port0), .pulse_busy(pulse_busy0)
    );

    bridge_pio_out #(.DATA_WIDTH(8), .RESET_VALUE(8'h81), .PULSE_CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1),
        .out_port(out_port1), .pulse_busy(pulse_busy1)
    );

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic        exp_busy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk1;
        logic [7:0]  exp_out1;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic cs, input logic wr,
                                input logic [2:0] addr, input logic [31:0] wdata,
                                input logic [7:0] eo, input logic eb,
                                input logic chk_rd, input logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.cs = cs; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_out = eo; v.exp_busy = eb; v.chk_rd = chk_rd; v.exp_rd = erd;
        v.chk1 = 1'b0; v.exp_out1 = 8'h00;
        return v;
    endfunction

    function automatic vec_t wrv(input logic [2:0] addr, input logic [31:0] wdata,
                                 input logic [7:0] eo, input logic eb);
        return mk(1'b0, 1'b1, 1'b1, addr, wdata, eo, eb, 1'b0, 32'h0);
    endfunction

    function automatic vec_t idl(input logic [2:0] addr, input logic [7:0] eo, input logic eb,
                                 input logic chk_rd, input logic [31:0] erd);
        return mk(1'b0, 1'b1, 1'b0, addr, 32'h0, eo, eb, chk_rd, erd);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        logic [31:0] rd_req;
        @(negedge clk);
        reset      = v.rst;
        chipselect = v.cs;
        write_n    = ~v.wr;
        address    = v.addr;
        writedata  = v.wdata;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
`ifdef BRIDGE_PIO_OUT_READBACK_EN
        rd_req = e.exp_rd;
`else
        rd_req = 32'h0;
`endif
        if (out_port0 !== e.exp_out) begin
            n_miss++;
            $display("FAIL out_port vec %0d: got %h expected %h", idx, out_port0, e.exp_out);
        end
        if (pulse_busy0 !== e.exp_busy) begin
            n_miss++;
            $display("FAIL pulse_busy vec %0d: got %b expected %b", idx, pulse_busy0, e.exp_busy);
        end
        if (e.chk_rd && (readdata0 !== rd_req)) begin
            n_miss++;
            $display("FAIL readdata vec %0d: got %h expected %h", idx, readdata0, rd_req);
        end
        if (e.chk1 && ((out_port1 !== e.exp_out1) || (pulse_busy1 !== e.exp_busy))) begin
            n_miss++;
            $display("FAIL rv81 vec %0d: got out %h busy %b expected out %h busy %b",
                     idx, out_port1, pulse_busy1, e.exp_out1, e.exp_busy);
        end
        $display("vec %0d: rst=%b cs=%b wr=%b addr=%0d wd=%h -> out=%h busy=%b rd=%h",
                 idx, v.rst, v.cs, v.wr, v.addr, v.wdata, out_port0, pulse_busy0, readdata0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;

        // reset, plain write, set/clear
        v = mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0);
        v.chk1 = 1'b1; v.exp_out1 = 8'h81;
        tbl.push_back(v);
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0));
        tbl.push_back(wrv(3'd0, 32'hA5, 8'hA5, 1'b0));
        tbl.push_back(idl(3'd0, 8'hA5, 1'b0, 1'b1, 32'hA5));
        tbl.push_back(wrv(3'd0, 32'hF0, 8'hF0, 1'b0));
        tbl.push_back(wrv(3'd4, 32'h03, 8'hF3, 1'b0));
        tbl.push_back(wrv(3'd5, 32'h30, 8'hC3, 1'b0));
        tbl.push_back(idl(3'd0, 8'hC3, 1'b0, 1'b1, 32'hC3));
        // 4-cycle pulse with counter readback
        tbl.push_back(wrv(3'd1, 32'd4, 8'hC3, 1'b0));
        tbl.push_back(wrv(3'd0, 32'h00, 8'h00, 1'b0));
        tbl.push_back(wrv(3'd2, 32'h01, 8'h01, 1'b1));
        tbl.push_back(idl(3'd3, 8'h01, 1'b1, 1'b1, 32'd4));
        tbl.push_back(idl(3'd3, 8'h01, 1'b1, 1'b1, 32'd3));
        tbl.push_back(idl(3'd3, 8'h01, 1'b1, 1'b1, 32'd2));
        tbl.push_back(idl(3'd3, 8'h00, 1'b0, 1'b1, 32'd1));
        tbl.push_back(idl(3'd3, 8'h00, 1'b0, 1'b1, 32'd0));
        // retrigger after 3 cycles, new pulse runs the full 10 cycles
        tbl.push_back(wrv(3'd1, 32'd10, 8'h00, 1'b0));
        tbl.push_back(wrv(3'd2, 32'h02, 8'h02, 1'b1));
        tbl.push_back(idl(3'd0, 8'h02, 1'b1, 1'b0, 32'h0));
        tbl.push_back(idl(3'd0, 8'h02, 1'b1, 1'b0, 32'h0));
        tbl.push_back(wrv(3'd2, 32'h04, 8'h04, 1'b1));
        tbl.push_back(idl(3'd2, 8'h04, 1'b1, 1'b1, 32'h80000004));
        for (int i = 0; i < 8; i++) tbl.push_back(idl(3'd0, 8'h04, 1'b1, 1'b0, 32'h0));
        tbl.push_back(idl(3'd0, 8'h00, 1'b0, 1'b0, 32'h0));
        // abort by trigger with len 0; len write mid-pulse leaves pulse alone
        tbl.push_back(wrv(3'd2, 32'h02, 8'h02, 1'b1));
        tbl.push_back(idl(3'd0, 8'h02, 1'b1, 1'b0, 32'h0));
        tbl.push_back(wrv(3'd1, 32'd0, 8'h02, 1'b1));
        tbl.push_back(wrv(3'd2, 32'h04, 8'h00, 1'b0));
        tbl.push_back(idl(3'd0, 8'h00, 1'b0, 1'b0, 32'h0));
        tbl.push_back(wrv(3'd2, 32'hFF, 8'h00, 1'b0));
        // zero-mask pulse still asserts busy
        tbl.push_back(wrv(3'd1, 32'd2, 8'h00, 1'b0));
        tbl.push_back(wrv(3'd2, 32'h00, 8'h00, 1'b1));
        tbl.push_back(idl(3'd0, 8'h00, 1'b1, 1'b0, 32'h0));
        tbl.push_back(idl(3'd0, 8'h00, 1'b0, 1'b0, 32'h0));
        // clear of a masked bit during a pulse shows only after the pulse
        tbl.push_back(wrv(3'd0, 32'h10, 8'h10, 1'b0));
        tbl.push_back(wrv(3'd1, 32'd3, 8'h10, 1'b0));
        tbl.push_back(wrv(3'd2, 32'h11, 8'h11, 1'b1));
        tbl.push_back(wrv(3'd5, 32'h11, 8'h11, 1'b1));
        tbl.push_back(idl(3'd0, 8'h11, 1'b1, 1'b0, 32'h0));
        tbl.push_back(idl(3'd0, 8'h00, 1'b0, 1'b0, 32'h0));
        // ignored writes, deselected write, upper data bits ignored
        tbl.push_back(wrv(3'd3, 32'hFF, 8'h00, 1'b0));
        tbl.push_back(wrv(3'd6, 32'hFF, 8'h00, 1'b0));
        tbl.push_back(wrv(3'd7, 32'hFF, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 32'hFF, 8'h00, 1'b0, 1'b0, 32'h0));
        tbl.push_back(wrv(3'd0, 32'hFFFFFF50, 8'h50, 1'b0));
        // 5-cycle pulse of mask 0x08 with readback
        tbl.push_back(wrv(3'd1, 32'd5, 8'h50, 1'b0));
        tbl.push_back(wrv(3'd2, 32'h08, 8'h58, 1'b1));
        tbl.push_back(idl(3'd3, 8'h58, 1'b1, 1'b1, 32'd5));
        tbl.push_back(idl(3'd3, 8'h58, 1'b1, 1'b1, 32'd4));
        tbl.push_back(idl(3'd3, 8'h58, 1'b1, 1'b1, 32'd3));
        tbl.push_back(idl(3'd2, 8'h58, 1'b1, 1'b1, 32'h80000008));
        tbl.push_back(idl(3'd3, 8'h50, 1'b0, 1'b1, 32'd1));
        tbl.push_back(idl(3'd4, 8'h50, 1'b0, 1'b1, 32'h0));
        tbl.push_back(idl(3'd1, 8'h50, 1'b0, 1'b1, 32'd5));
        tbl.push_back(idl(3'd0, 8'h50, 1'b0, 1'b1, 32'h50));
        tbl.push_back(idl(3'd7, 8'h50, 1'b0, 1'b1, 32'h0));

        foreach (tbl[i]) apply(tbl[i], i);

        // hand-written: reset in the middle of a 100-cycle pulse
        apply(wrv(3'd0, 32'h00, 8'h00, 1'b0), 1000);
        apply(wrv(3'd1, 32'd100, 8'h00, 1'b0), 1001);
        apply(wrv(3'd2, 32'h40, 8'h40, 1'b1), 1002);
        for (int i = 0; i < 49; i++) apply(idl(3'd0, 8'h40, 1'b1, 1'b0, 32'h0), 1003 + i);
        v = mk(1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0);
        v.chk1 = 1'b1; v.exp_out1 = 8'h81;
        apply(v, 1100);
        v = idl(3'd3, 8'h00, 1'b0, 1'b1, 32'h0);
        v.chk1 = 1'b1; v.exp_out1 = 8'h81;
        apply(v, 1101);
        v = idl(3'd2, 8'h00, 1'b0, 1'b1, 32'h0);
        v.chk1 = 1'b1; v.exp_out1 = 8'h81;
        apply(v, 1102);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bridge_pio_out.md
Name: bridge_pio_out

Overview:
- Avalon-MM write slave driving a parallel output port from the HPS/Nios bridge to fabric logic (LEDs, strobes, control lines).
- Complements the input PIO: software writes, fabric reads.
- Adds atomic bit set/clear and a hardware one-shot pulse generator, so software can emit timed strobes without busy-waiting.

Parameters:
- DATA_WIDTH, 8, width of out_port and of all data/mask registers (1..32).
- RESET_VALUE, 0, value loaded into the data register on reset.
- PULSE_CNT_WIDTH, 16, width of the pulse length register and pulse counter (1..32).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register select (word address).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is accepted when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  registered read data (see Optional Feature).
- out_port  out  DATA_WIDTH  output to fabric.
- pulse_busy  out  1  high while a one-shot pulse is active.

Behaviour:
- Registers: data_reg[DATA_WIDTH], len_reg[PULSE_CNT_WIDTH], mask_reg[DATA_WIDTH], cnt[PULSE_CNT_WIDTH], busy.
- Address map, on an accepted write:
  - 0: data_reg <= writedata.
  - 1: len_reg <= writedata[PULSE_CNT_WIDTH-1:0].
  - 2: pulse trigger, described below.
  - 4: outset, data_reg <= data_reg | writedata.
  - 5: outclear, data_reg <= data_reg & ~writedata.
  - 3, 6, 7: writes ignored.
- out_port = data_reg | (busy ? mask_reg : 0). It is built only from registers, with no combinational path from bus inputs. A write is visible on out_port the cycle after the edge that accepts it.
- pulse_busy = busy.
- Pulse FSM, two states:
  - IDLE (busy=0): on a trigger with len_reg != 0: mask_reg <= writedata, cnt <= len_reg, go to PULSE.
  - IDLE, trigger with len_reg == 0: no effect.
  - PULSE (busy=1): cnt decrements each cycle. At cnt==1 with no trigger, go to IDLE and set cnt <= 0.
  - mask_reg is ORed onto out_port for exactly len_reg cycles.
  - PULSE, trigger with len_reg != 0: retrigger. mask_reg is replaced, cnt reloads to len_reg, stay in PULSE; the new pulse lasts len_reg cycles from the next edge.
  - PULSE, trigger with len_reg == 0: abort; go to IDLE and set cnt <= 0 at that edge.
- A trigger with writedata mask = 0 still runs the FSM (busy asserted) with out_port unchanged.
- Writes to len_reg during PULSE do not affect the pulse in flight.
- Writes to data_reg, outset and outclear during PULSE take effect normally. A bit set in mask_reg stays high until the pulse ends, then shows its data_reg value.
- Wrap-around: the counter never underflows; cnt==0 is reached only via IDLE.
- Reset (any cycle, including mid-pulse), values at the next edge:
  - data_reg = RESET_VALUE; len_reg, mask_reg and cnt = 0; busy = 0; readdata = 0.
  - out_port = RESET_VALUE.
  - Any pulse in progress is dropped.
- Accepted writes complete in one cycle with zero wait states.

Optional Feature:
- Macro: BRIDGE_PIO_OUT_READBACK_EN.
- Defined: readdata is registered every clk from the decode of address (read latency 1, independent of chipselect), zero-extended:
  - 0: data_reg.
  - 1: len_reg.
  - 2: bit 31 = busy, low bits = mask_reg.
  - 3: cnt.
  - Other addresses: 0.
- Not defined: readdata is tied to 32'h0 and no read mux is synthesised.

Test Plan:
- Reset, then write addr0 = 0xA5 -> out_port = 0x00 during reset, then 0xA5 one cycle after the write edge; pulse_busy = 0.
- data_reg = 0xF0; outset 0x03; outclear 0x30 -> out_port = 0xF3, then 0xC3.
- len_reg = 4, data_reg = 0, trigger mask 0x01 -> out_port = 0x01 for exactly 4 cycles, pulse_busy high for the same 4 cycles, then out_port = 0x00.
- len_reg = 10, trigger 0x02; after 3 cycles trigger 0x04 -> out_port = 0x02 for 3 cycles, then 0x04 for 10 cycles. Repeat the case with len_reg = 0 written before the second trigger -> pulse aborts and out_port = 0x00 at the next edge.
- Assert reset mid-pulse (len_reg = 100, cycle 50) with RESET_VALUE = 0x81 -> next edge: out_port = 0x81, pulse_busy = 0, cnt = 0.
- With BRIDGE_PIO_OUT_READBACK_EN during a len_reg = 5 pulse of mask 0x08: read addr2 returns 0x80000008, addr3 shows cnt decrementing 5..1. Without the macro, every address reads 0.
